hb_interp_scheduler: RTL and testbench

//  Time-multiplexes one shared half-band interpolation datapath (E0 delay branch + odd FIR branch)

---
 rtl/hb_pkg.sv | 16 +
 rtl/hb_interp_scheduler_if.sv | 31 +++
 rtl/hb_rr_arbiter.sv | 25 ++
 rtl/hb_interp_scheduler.sv | 127 ++++++++++++
 tb/tb_hb_interp_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hb_pkg.sv
// Shared types and constants for the half-band interpolation scheduler.
package hb_pkg;

   typedef enum logic [2:0] {
      ARB     = 3'd0,
      ISSUE_E = 3'd1,
      WAIT_E  = 3'd2,
      ISSUE_O = 3'd3,
      WAIT_O  = 3'd4
   } hb_state_e;

   localparam logic PH_EVEN = 1'b0;
   localparam logic PH_ODD  = 1'b1;
   localparam int   HB_DW   = 15;

endpackage

// File: rtl/hb_interp_scheduler_if.sv
// Channel-source and datapath signals of the half-band scheduler, grouped as one bundle.
interface hb_interp_scheduler_if #(
   parameter int N_CH = 2,
   parameter int DW   = hb_pkg::HB_DW,
   parameter int CH_W = $clog2(N_CH)
) ();

   logic [N_CH-1:0]    s_valid;
   logic [N_CH*DW-1:0] s_data;
   logic [N_CH-1:0]    s_ready;
   logic               dp_start;
   logic [CH_W-1:0]    dp_ch;
   logic               dp_phase;
   logic [DW-1:0]      dp_sample;
   logic               dp_done;
   logic               busy;
   logic               err;

   // scheduler side
   modport master (
      input  s_valid, s_data, dp_done,
      output s_ready, dp_start, dp_ch, dp_phase, dp_sample, busy, err
   );

   // sources + datapath side
   modport slave (
      output s_valid, s_data, dp_done,
      input  s_ready, dp_start, dp_ch, dp_phase, dp_sample, busy, err
   );

endinterface

// File: rtl/hb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N_CH.
module hb_rr_arbiter #(
   parameter int N_CH = 2,
   parameter int CH_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req_i,
   input  logic [CH_W-1:0] ptr_i,
   output logic [CH_W-1:0] grant_o,
   output logic            any_req_o
);

   int idx;

   // Scan from farthest to nearest so the closest requester to ptr wins last.
   always_comb begin
      grant_o   = '0;
      any_req_o = |req_i;
      idx       = 0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = (int'(ptr_i) + k) % N_CH;
         if (req_i[idx]) grant_o = CH_W'(idx);
      end
   end

endmodule

// File: rtl/hb_interp_scheduler.sv
// Shares one half-band datapath across N_CH Tx channels: RR grant, then even and odd ops.
// Optional dp_done watchdog enabled by defining HB_SCHED_TIMEOUT_EN.
module hb_interp_scheduler
   import hb_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int DW      = HB_DW,
   parameter int CH_W    = $clog2(N_CH),
   parameter int TMO_CYC = 16
) (
   input  logic           clk,
   input  logic           rst,
   hb_interp_scheduler_if.master bus
);

   if (N_CH < 2 || TMO_CYC < 1) begin : g_param_chk
      $error("hb_interp_scheduler: N_CH must be >= 2 and TMO_CYC >= 1");
   end

   hb_state_e       state_q, state_d;
   logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic [DW-1:0]   sample_q, sample_d;
   logic [N_CH-1:0] ready;
   logic [CH_W-1:0] grant;
   logic            any_req;

   hb_rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
      .req_i     (bus.s_valid),
      .ptr_i     (rr_ptr_q),
      .grant_o   (grant),
      .any_req_o (any_req)
   );

`ifdef HB_SCHED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
   logic             tmo_hit;

   assign tmo_hit = (tmo_q == TMO_W'(TMO_CYC - 1));
`endif

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      ch_d     = ch_q;
      sample_d = sample_q;
      ready    = '0;
`ifdef HB_SCHED_TIMEOUT_EN
      tmo_d    = tmo_q;
      err_d    = err_q;
`endif
      case (state_q)
         ARB: begin
            if (any_req) begin
               ready[grant] = 1'b1;
               sample_d     = bus.s_data[int'(grant)*DW +: DW];
               ch_d         = grant;
               rr_ptr_d     = (int'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
               state_d      = ISSUE_E;
            end
         end
         ISSUE_E: begin
            state_d = WAIT_E;
`ifdef HB_SCHED_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         ISSUE_O: begin
            state_d = WAIT_O;
`ifdef HB_SCHED_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         WAIT_E, WAIT_O: begin
            if (bus.dp_done) begin
               state_d = (state_q == WAIT_E) ? ISSUE_O : ARB;
`ifdef HB_SCHED_TIMEOUT_EN
            end else if (tmo_hit) begin
               // Abandon whatever phase remains; the channel is not re-queued.
               err_d   = 1'b1;
               state_d = ARB;
            end else begin
               tmo_d   = tmo_q + 1'b1;
`endif
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ARB;
         rr_ptr_q <= '0;
         ch_q     <= '0;
         sample_q <= '0;
`ifdef HB_SCHED_TIMEOUT_EN
         tmo_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         ch_q     <= ch_d;
         sample_q <= sample_d;
`ifdef HB_SCHED_TIMEOUT_EN
         tmo_q    <= tmo_d;
         err_q    <= err_d;
`endif
      end
   end

   assign bus.s_ready   = ready;
   assign bus.dp_start  = (state_q == ISSUE_E) || (state_q == ISSUE_O);
   assign bus.dp_phase  = (state_q == ISSUE_O || state_q == WAIT_O) ? PH_ODD : PH_EVEN;
   assign bus.dp_ch     = ch_q;
   assign bus.dp_sample = sample_q;
   assign bus.busy      = (state_q != ARB);
`ifdef HB_SCHED_TIMEOUT_EN
   assign bus.err       = err_q;
`else
   assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_hb_interp_scheduler.sv
// Self-checking bench for hb_interp_scheduler: directed table, corner sequences, random vs model.
module tb_hb_interp_scheduler;

   localparam int N_CH = 2;
   localparam int DW   = 15;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   hb_interp_scheduler_if #(.N_CH(N_CH), .DW(DW)) bus ();

   hb_interp_scheduler #(.N_CH(N_CH), .DW(DW), .TMO_CYC(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   typedef struct {
      logic [1:0]    v;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      int            ch;
      logic [DW-1:0] smp;
      int            stall_o;
   } vec_t;

   vec_t tv[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst          = 1'b1;
      bus.s_valid  = '0;
      bus.dp_done  = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      chk({tag, ".busy"},   32'(bus.busy),      32'd0);
      chk({tag, ".start"},  32'(bus.dp_start),  32'd0);
      chk({tag, ".ready"},  32'(bus.s_ready),   32'd0);
      chk({tag, ".err"},    32'(bus.err),       32'd0);
      chk({tag, ".ch"},     32'(bus.dp_ch),     32'd0);
      chk({tag, ".phase"},  32'(bus.dp_phase),  32'd0);
      chk({tag, ".sample"}, 32'(bus.dp_sample), 32'd0);
   endtask

   // One issue cycle then n_wait cycles without done, then the done cycle.
   // Sources toggle randomly meanwhile: the op in flight must not notice.
   task automatic do_phase(input int ch, input logic [DW-1:0] smp, input logic ph,
                           input logic stray, input int n_wait, input string tag);
      bus.s_valid = 2'($urandom);
      bus.s_data  = 30'($urandom);
      bus.dp_done = stray;
      #1;
      chk({tag, ".istart"},  32'(bus.dp_start),  32'd1);
      chk({tag, ".iphase"},  32'(bus.dp_phase),  32'(ph));
      chk({tag, ".ich"},     32'(bus.dp_ch),     32'(ch));
      chk({tag, ".isample"}, 32'(bus.dp_sample), 32'(smp));
      chk({tag, ".iready"},  32'(bus.s_ready),   32'd0);
      step();
      for (int i = 0; i <= n_wait; i++) begin
         bus.s_valid = 2'($urandom);
         bus.dp_done = (i == n_wait);
         #1;
         chk({tag, ".wstart"},  32'(bus.dp_start),  32'd0);
         chk({tag, ".wready"},  32'(bus.s_ready),   32'd0);
         chk({tag, ".wbusy"},   32'(bus.busy),      32'd1);
         chk({tag, ".wphase"},  32'(bus.dp_phase),  32'(ph));
         chk({tag, ".wch"},     32'(bus.dp_ch),     32'(ch));
         chk({tag, ".wsample"}, 32'(bus.dp_sample), 32'(smp));
         chk({tag, ".werr"},    32'(bus.err),       32'd0);
         step();
      end
   endtask

   task automatic run_txn(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input int ch, input logic [DW-1:0] smp, input logic stray,
                          input int stall_e, input int stall_o, input string tag);
      bus.s_valid = v;
      bus.s_data  = {d1, d0};
      bus.dp_done = 1'b0;
      #1;
      chk({tag, ".grant"}, 32'(bus.s_ready), 32'(1 << ch));
      chk({tag, ".abusy"}, 32'(bus.busy),    32'd0);
      step();
      do_phase(ch, smp, 1'b0, stray, stall_e, {tag, ".e"});
      do_phase(ch, smp, 1'b1, 1'b0, stall_o, {tag, ".o"});
      bus.s_valid = '0;
      bus.dp_done = 1'b0;
      #1;
      chk({tag, ".endbusy"},  32'(bus.busy),     32'd0);
      chk({tag, ".endstart"}, 32'(bus.dp_start), 32'd0);
   endtask

   initial begin
      int            ptr;
      int            g;
      logic [1:0]    v;
      logic [29:0]   d;
      logic [DW-1:0] smp;

      rst         = 1'b1;
      bus.s_valid = '0;
      bus.s_data  = '0;
      bus.dp_done = 1'b0;
      do_reset("rst0");

      // Reset in the middle of WAIT_E after a ch0 grant moved the pointer to 1.
      bus.s_valid = 2'b01;
      bus.s_data  = {15'd0, 15'd77};
      #1;
      chk("mid.grant", 32'(bus.s_ready), 32'd1);
      step();
      bus.s_valid = '0;
      step();
      #1;
      chk("mid.inwait", 32'(bus.busy), 32'd1);
      do_reset("rst1");
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst1.nostart", 32'(bus.dp_start), 32'd0);
         chk("rst1.idle",    32'(bus.busy),     32'd0);
      end
      run_txn(2'b11, 15'd9, 15'd10, 0, 15'd9, 1'b0, 0, 0, "ptr0");

      // Table: pointer starts at 0 after reset; grants traced by hand.
      tv[0] = '{2'b01, 15'd1234,  15'h7fff, 0, 15'd1234,  0};
      tv[1] = '{2'b11, 15'h0055,  15'h4000, 1, 15'h4000,  0};
      tv[2] = '{2'b11, 15'h7ffb,  15'h0001, 0, 15'h7ffb,  7};
      tv[3] = '{2'b11, 15'h1111,  15'h2222, 1, 15'h2222,  0};
      tv[4] = '{2'b10, 15'h3333,  15'h4444, 1, 15'h4444,  0};
      tv[5] = '{2'b10, 15'h0000,  15'h7fff, 1, 15'h7fff,  2};
      tv[6] = '{2'b01, 15'h2aaa,  15'h5555, 0, 15'h2aaa,  0};
      tv[7] = '{2'b01, 15'h0001,  15'h0002, 0, 15'h0001,  1};
      do_reset("rst2");
      foreach (tv[i])
         run_txn(tv[i].v, tv[i].d0, tv[i].d1, tv[i].ch, tv[i].smp, 1'b0, 0, tv[i].stall_o,
                 $sformatf("tv%0d", i));

      // Stray dp_done while idle and in ISSUE_E must not advance anything (pointer is 1 now).
      for (int i = 0; i < 2; i++) begin
         bus.s_valid = '0;
         bus.dp_done = 1'b1;
         #1;
         chk("stray.idle", 32'(bus.busy), 32'd0);
         step();
      end
      run_txn(2'b11, 15'd5, 15'd6, 1, 15'd6, 1'b1, 2, 0, "stray");

`ifdef HB_SCHED_TIMEOUT_EN
      do_reset("rst3");
      bus.s_valid = 2'b01;
      bus.s_data  = {15'd0, 15'd321};
      #1;
      chk("tmo.grant", 32'(bus.s_ready), 32'd1);
      step();
      bus.s_valid = '0;
      #1;
      chk("tmo.istart", 32'(bus.dp_start), 32'd1);
      step();
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("tmo.wbusy", 32'(bus.busy), 32'd1);
         chk("tmo.werr",  32'(bus.err),  32'd0);
         step();
      end
      #1;
      chk("tmo.arb",   32'(bus.busy),     32'd0);
      chk("tmo.err",   32'(bus.err),      32'd1);
      chk("tmo.start", 32'(bus.dp_start), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("tmo.sticky", 32'(bus.err), 32'd1);
      end
      do_reset("rst4");
`else
      run_txn(2'b01, 15'd4321, 15'd0, 0, 15'd4321, 1'b0, 20, 0, "longwait");
`endif

      // Random traffic against a transaction-level model of the round-robin rules.
      do_reset("rst5");
      ptr = 0;
      for (int t = 0; t < 300; t++) begin
         v           = 2'($urandom);
         d           = 30'($urandom);
         bus.s_valid = v;
         bus.s_data  = d;
         bus.dp_done = 1'($urandom);
         #1;
         if (v == 2'b00) begin
            chk("rnd.noreq", 32'(bus.s_ready), 32'd0);
            chk("rnd.idle",  32'(bus.busy),    32'd0);
            step();
         end else begin
            g = v[ptr] ? ptr : (ptr + 1) % N_CH;
            smp = d[g*DW +: DW];
            chk("rnd.grant", 32'(bus.s_ready), 32'(1 << g));
            ptr = (g + 1) % N_CH;
            step();
            do_phase(g, smp, 1'b0, 1'($urandom), $urandom_range(0, 5), "rnd.e");
            do_phase(g, smp, 1'b1, 1'($urandom), $urandom_range(0, 5), "rnd.o");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
